// File: rtl/reg_renamer_pkg.sv
// Shared types and sizes for the decode-stage register renamer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package reg_renamer_pkg;

    localparam int ARCH_REGS  = 32;
    localparam int PHYS_REGS  = 64;
    localparam int FREE_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int WB_GROUP_W = 1;

    typedef logic [4:0]            rs_addr_t;
    typedef logic [5:0]            phys_addr_t;
    typedef logic [WB_GROUP_W-1:0] wb_group_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } renamer_state_t;

    typedef struct packed {
        phys_addr_t phys;
        wb_group_t  group;
    } map_entry_t;

    typedef struct packed {
        logic       valid;
        rs_addr_t   rd;
        phys_addr_t old_phys;
        wb_group_t  old_group;
        phys_addr_t new_phys;
    } renamer_id_entry_t;

endpackage

// File: rtl/reg_renamer_free_list.sv
// Circular FIFO of unallocated physical registers (optional RENAMER_FREE_LIST_BYPASS_EN).
// Latency: head is combinational; push/pop take effect at the next clock edge.
// Backpressure: none internally; owner must only pop when non-empty (or bypassing).
module reg_renamer_free_list
    import reg_renamer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  phys_addr_t push_phys,
    input  logic       pop,
    output phys_addr_t head,
    output logic [5:0] count,
    output logic       bypass
);

    phys_addr_t mem [FREE_DEPTH];
    logic [4:0] head_ptr;
    logic [4:0] tail_ptr;
    logic       do_push;
    logic       do_pop;

`ifdef RENAMER_FREE_LIST_BYPASS_EN
    // An empty list can hand a register being pushed straight to the pop side.
    assign bypass = (count == 6'd0) && push;
`else
    assign bypass = 1'b0;
`endif

    assign head    = bypass ? push_phys : mem[head_ptr];
    // A bypassed push+pop never touches storage; otherwise push and pop are independent.
    assign do_push = push && !(bypass && pop);
    assign do_pop  = pop && (count != 6'd0);

    // Storage is written only at the tail; no reset needed since count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail_ptr] <= push_phys;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + 5'd1;
            if (do_pop)  head_ptr <= head_ptr + 5'd1;
            count <= count + 6'(do_push) - 6'(do_pop);
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && count == 6'(FREE_DEPTH)));

endmodule

// File: rtl/reg_renamer.sv
// Renames 32 architectural onto 64 physical registers; retire recycles, rollback restores (optional RENAMER_FREE_LIST_BYPASS_EN).
// Latency: source/destination lookups are combinational; map/free-list/ID updates land next edge.
// Backpressure: rename_ready low during the 32-cycle init and whenever no free register exists.
module reg_renamer
    import reg_renamer_pkg::*;
#(
    parameter int NUM_WB_GROUPS = 2,
    parameter int READ_PORTS    = 2,
    parameter int MAX_IDS       = 8
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [READ_PORTS-1:0][4:0]                     decode_rs_addr,
    input  logic [4:0]                                     decode_rd_addr,
    input  logic                                           decode_uses_rd,
    input  logic [$clog2(NUM_WB_GROUPS)-1:0]               decode_rd_wb_group,
    input  logic [$clog2(MAX_IDS)-1:0]                     decode_id,
    input  logic                                           decode_advance,
    output logic                                           rename_ready,
    output logic [READ_PORTS-1:0][5:0]                     decode_phys_rs_addr,
    output logic [READ_PORTS-1:0][$clog2(NUM_WB_GROUPS)-1:0] decode_rs_wb_group,
    output logic [5:0]                                     decode_phys_rd_addr,
    input  logic                                           retire_valid,
    input  logic [$clog2(MAX_IDS)-1:0]                     retire_id,
    input  logic                                           rollback_valid,
    input  logic [$clog2(MAX_IDS)-1:0]                     rollback_id
);

    localparam int GW = $clog2(NUM_WB_GROUPS);

    renamer_state_t    state;
    renamer_state_t    state_next;
    logic              run;
    logic              init_wr;
    rs_addr_t          init_idx;
    map_entry_t        map_q    [ARCH_REGS];
    renamer_id_entry_t id_table [MAX_IDS];
    renamer_id_entry_t ret_entry;
    renamer_id_entry_t rb_entry;
    logic              ret_hit;
    logic              rb_hit;
    logic              rename;
    logic              fl_push;
    phys_addr_t        fl_push_phys;
    logic              fl_pop;
    phys_addr_t        fl_head;
    logic [5:0]        fl_count;
    logic              fl_bypass;

    // State register: INIT after reset, RUN forever once the map is seeded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_next;
    end

    // Next state: leave INIT after the last architectural register is seeded.
    always_comb begin
        state_next = state;
        if (state == ST_INIT && init_idx == 5'd31) state_next = ST_RUN;
    end

    // State decode used by the datapath.
    always_comb begin
        run     = (state == ST_RUN);
        init_wr = (state == ST_INIT);
    end

    // Init sweep counter: one architectural register per INIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       init_idx <= '0;
        else if (init_wr) init_idx <= init_idx + 5'd1;
    end

    assign rename       = decode_advance && decode_uses_rd && (decode_rd_addr != 5'd0);
    assign ret_entry    = id_table[retire_id];
    assign rb_entry     = id_table[rollback_id];
    assign ret_hit      = run && retire_valid && ret_entry.valid;
    assign rb_hit       = run && rollback_valid && rb_entry.valid;
    assign fl_push      = init_wr || ret_hit || rb_hit;
    assign fl_push_phys = init_wr ? {1'b1, init_idx} :
                          ret_hit ? ret_entry.old_phys : rb_entry.new_phys;
    assign rename_ready = run && ((fl_count != 6'd0) || fl_bypass);
    assign fl_pop       = rename && rename_ready;
    // Nothing is allocatable until RUN, so the destination reads as zero before then.
    assign decode_phys_rd_addr = run ? fl_head : '0;

    reg_renamer_free_list u_free_list (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fl_push),
        .push_phys (fl_push_phys),
        .pop       (fl_pop),
        .head      (fl_head),
        .count     (fl_count),
        .bypass    (fl_bypass)
    );

    // Source lookup reads the registered map, so same-cycle renames are not visible; x0 is hardwired.
    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            decode_phys_rs_addr[p] = '0;
            decode_rs_wb_group[p]  = '0;
            if (decode_rs_addr[p] != 5'd0) begin
                decode_phys_rs_addr[p] = map_q[decode_rs_addr[p]].phys;
                decode_rs_wb_group[p]  = GW'(map_q[decode_rs_addr[p]].group);
            end
        end
    end

    // Map: seeded identity during INIT; rollback restores first so a same-cycle rename wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= '0;
        end else if (init_wr) begin
            map_q[init_idx] <= '{phys: {1'b0, init_idx}, group: '0};
        end else begin
            if (rb_hit) map_q[rb_entry.rd] <= '{phys: rb_entry.old_phys, group: rb_entry.old_group};
            if (fl_pop) map_q[decode_rd_addr] <= '{phys: fl_head, group: wb_group_t'(decode_rd_wb_group)};
        end
    end

    // ID table: retire/rollback invalidate first, then the decoding instruction's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_IDS; i++) id_table[i] <= '0;
        end else if (run) begin
            if (ret_hit) id_table[retire_id].valid   <= 1'b0;
            if (rb_hit)  id_table[rollback_id].valid <= 1'b0;
            if (fl_pop) begin
                id_table[decode_id] <= '{valid:     1'b1,
                                         rd:        decode_rd_addr,
                                         old_phys:  map_q[decode_rd_addr].phys,
                                         old_group: map_q[decode_rd_addr].group,
                                         new_phys:  fl_head};
            end else if (decode_advance) begin
                id_table[decode_id].valid <= 1'b0;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(rename && !rename_ready));
    assert property (@(posedge clk) disable iff (!rst_n) !(retire_valid && rollback_valid));

endmodule

// File: tb/tb_reg_renamer.sv
module tb_reg_renamer;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0][4:0] rs_addr;
    logic [4:0]      rd_addr;
    logic            uses_rd;
    logic [0:0]      rd_grp;
    logic [2:0]      dec_id;
    logic            adv;
    logic            ready;
    logic [1:0][5:0] phys_rs;
    logic [1:0][0:0] rs_grp;
    logic [5:0]      phys_rd;
    logic            ret_v;
    logic [2:0]      ret_id;
    logic            rb_v;
    logic [2:0]      rb_id;

`ifdef RENAMER_FREE_LIST_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_renamer #(.NUM_WB_GROUPS(2), .READ_PORTS(2), .MAX_IDS(8)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .decode_rs_addr      (rs_addr),
        .decode_rd_addr      (rd_addr),
        .decode_uses_rd      (uses_rd),
        .decode_rd_wb_group  (rd_grp),
        .decode_id           (dec_id),
        .decode_advance      (adv),
        .rename_ready        (ready),
        .decode_phys_rs_addr (phys_rs),
        .decode_rs_wb_group  (rs_grp),
        .decode_phys_rd_addr (phys_rd),
        .retire_valid        (ret_v),
        .retire_id           (ret_id),
        .rollback_valid      (rb_v),
        .rollback_id         (rb_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural map, free list as a queue, per-ID records.
    int m_phys [32];
    int m_grp  [32];
    int freeq  [$];
    bit t_valid [8];
    int t_rd [8];
    int t_oldp [8];
    int t_oldg [8];
    int t_newp [8];
    int inflight [$];
    int init_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin m_phys[i] = 0; m_grp[i] = 0; end
        for (int i = 0; i < 8; i++) t_valid[i] = 1'b0;
        freeq.delete();
        inflight.delete();
        init_done = 0;
    endtask

    task automatic drop_inflight(input int id);
        for (int i = 0; i < inflight.size(); i++)
            if (inflight[i] == id) begin inflight.delete(i); break; end
    endtask

    task automatic pending_push(output bit pushing, output int pv);
        pushing = 1'b0;
        pv = 0;
        if (init_done == 32 && ret_v && t_valid[ret_id]) begin pushing = 1'b1; pv = t_oldp[ret_id]; end
        else if (init_done == 32 && rb_v && t_valid[rb_id]) begin pushing = 1'b1; pv = t_newp[rb_id]; end
    endtask

    // Compare all meaningful outputs against the model.
    task automatic check_outputs();
        bit pushing;
        int pv;
        bit exp_rdy;
        pending_push(pushing, pv);
        exp_rdy = (init_done == 32) && (freeq.size() != 0 || (BYPASS && pushing));
        chk("rename_ready", ready, exp_rdy);
        if (exp_rdy) chk("phys_rd", phys_rd, freeq.size() != 0 ? freeq[0] : pv);
        for (int p = 0; p < 2; p++) begin
            chk("phys_rs", phys_rs[p], rs_addr[p] == 0 ? 0 : m_phys[rs_addr[p]]);
            chk("rs_group", rs_grp[p], rs_addr[p] == 0 ? 0 : m_grp[rs_addr[p]]);
        end
        chk("free_count", dut.fl_count, freeq.size());
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic step_model();
        bit rn;
        bit pushing;
        int pv;
        int hd;
        int old_p;
        int old_g;
        if (init_done < 32) begin
            m_phys[init_done] = init_done;
            m_grp[init_done] = 0;
            freeq.push_back(32 + init_done);
            init_done++;
            return;
        end
        rn = adv && uses_rd && rd_addr != 0;
        old_p = m_phys[rd_addr];
        old_g = m_grp[rd_addr];
        pending_push(pushing, pv);
        if (ret_v && t_valid[ret_id]) begin
            t_valid[ret_id] = 1'b0;
            drop_inflight(ret_id);
        end
        if (rb_v && t_valid[rb_id]) begin
            m_phys[t_rd[rb_id]] = t_oldp[rb_id];
            m_grp[t_rd[rb_id]] = t_oldg[rb_id];
            t_valid[rb_id] = 1'b0;
            drop_inflight(rb_id);
        end
        if (rn) begin
            if (freeq.size() == 0) begin hd = pv; pushing = 1'b0; end
            else hd = freeq.pop_front();
            m_phys[rd_addr] = hd;
            m_grp[rd_addr] = rd_grp;
            t_valid[dec_id] = 1'b1;
            t_rd[dec_id] = rd_addr;
            t_oldp[dec_id] = old_p;
            t_oldg[dec_id] = old_g;
            t_newp[dec_id] = hd;
            drop_inflight(dec_id);
            inflight.push_back(dec_id);
        end else if (adv) begin
            t_valid[dec_id] = 1'b0;
            drop_inflight(dec_id);
        end
        if (pushing) freeq.push_back(pv);
    endtask

    task automatic eval_cycle();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic advance_cycle();
        @(posedge clk);
        step_model();
        #1;
    endtask

    task automatic set_idle(input int rs0);
        adv = 0; uses_rd = 0; rd_addr = 0; rd_grp = 0; dec_id = 0;
        ret_v = 0; ret_id = 0; rb_v = 0; rb_id = 0;
        rs_addr[0] = 5'(rs0); rs_addr[1] = 5'd0;
    endtask

    task automatic set_dec(input int rs0, input bit u, input int rd, input int g, input int id);
        set_idle(rs0);
        adv = 1; uses_rd = u; rd_addr = 5'(rd); rd_grp = 1'(g); dec_id = 3'(id);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        set_idle(5);
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_phys_rd", phys_rd, 0);
        chk("rst_phys_rs0", phys_rs[0], 0);
        chk("rst_phys_rs1", phys_rs[1], 0);
        chk("rst_rs_group", rs_grp[0], 0);
        chk("rst_count", dut.fl_count, 0);
        chk("rst_counter", dut.init_idx, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_init();
        for (int k = 0; k < 32; k++) begin
            set_idle(5);
            eval_cycle();
            chk("init_ready_low", ready, 0);
            advance_cycle();
        end
        eval_cycle();
        chk("init_ready_high", ready, 1);
        chk("init_x5_phys", phys_rs[0], 5);
        chk("init_x5_group", rs_grp[0], 0);
        chk("init_count", dut.fl_count, 32);
        advance_cycle();
    endtask

    task automatic rand_stim();
        int r;
        int cand [$];
        bit pushing;
        int pv;
        rs_addr[0] = 5'($urandom_range(0, 31));
        rs_addr[1] = 5'($urandom_range(0, 31));
        ret_v = 0; rb_v = 0;
        ret_id = 3'($urandom_range(0, 7));
        rb_id = 3'($urandom_range(0, 7));
        r = $urandom_range(0, 9);
        if (r < 3 && inflight.size() != 0) begin ret_v = 1; ret_id = 3'(inflight[0]); end
        else if (r == 3 && inflight.size() != 0) begin rb_v = 1; rb_id = 3'(inflight[$]); end
        else if (r == 4 && !t_valid[ret_id]) ret_v = 1;
        for (int i = 0; i < 8; i++) if (!t_valid[i]) cand.push_back(i);
        adv = (cand.size() != 0) && ($urandom_range(0, 3) != 0);
        dec_id = adv ? 3'(cand[$urandom_range(0, cand.size() - 1)]) : 3'd0;
        uses_rd = ($urandom_range(0, 7) != 0);
        rd_addr = 5'($urandom_range(0, 31));
        rd_grp = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) rs_addr[1] = rd_addr;
        pending_push(pushing, pv);
        if (freeq.size() == 0 && !(BYPASS && pushing)) uses_rd = 0;
    endtask

    initial begin
        set_idle(5);
        apply_reset();
        run_init();

        // First rename of x5; same-cycle source still sees the old mapping.
        set_dec(5, 1, 5, 1, 0);
        eval_cycle();
        chk("x5_rename_rd", phys_rd, 32);
        chk("x5_same_cycle_rs", phys_rs[0], 5);
        advance_cycle();
        set_idle(5);
        eval_cycle();
        chk("x5_next_phys", phys_rs[0], 32);
        chk("x5_next_group", rs_grp[0], 1);
        advance_cycle();

        // Drain the free list with 31 more renames, then recycle via retire of id 0.
        for (int k = 0; k < 31; k++) begin
            set_dec(0, 1, (k % 31) + 1, k & 1, (k % 7) + 1);
            eval_cycle();
            advance_cycle();
        end
        set_idle(5);
        eval_cycle();
        chk("drained_ready", ready, 0);
        advance_cycle();
        set_idle(5);
        ret_v = 1; ret_id = 0;
        eval_cycle();
`ifdef RENAMER_FREE_LIST_BYPASS_EN
        chk("bypass_ready", ready, 1);
        chk("bypass_rd", phys_rd, 5);
`else
        chk("retire_same_ready", ready, 0);
`endif
        advance_cycle();
        set_idle(5);
        eval_cycle();
        chk("retire_next_ready", ready, 1);
        chk("retire_next_rd", phys_rd, 5);
        advance_cycle();

        // Two renames of x7 rolled back youngest-first.
        apply_reset();
        run_init();
        set_dec(7, 1, 7, 1, 2);
        eval_cycle(); chk("x7_first_rd", phys_rd, 32); advance_cycle();
        set_dec(7, 1, 7, 0, 3);
        eval_cycle(); chk("x7_second_rd", phys_rd, 33); chk("x7_second_rs", phys_rs[0], 32); advance_cycle();
        set_idle(7); rb_v = 1; rb_id = 3;
        eval_cycle(); advance_cycle();
        set_idle(7); rb_v = 1; rb_id = 2;
        eval_cycle(); chk("x7_mid_restore", phys_rs[0], 32); advance_cycle();
        set_idle(7);
        eval_cycle(); chk("x7_restored", phys_rs[0], 7); chk("x7_restored_grp", rs_grp[0], 0); advance_cycle();
        for (int k = 0; k < 32; k++) begin
            set_dec(0, 1, (k % 31) + 1, 0, k % 8);
            eval_cycle();
            if (k == 30) chk("freed_order_33", phys_rd, 33);
            if (k == 31) chk("freed_order_32", phys_rd, 32);
            advance_cycle();
        end

        // Advances that do not rename neither pop nor, on retire, push.
        apply_reset();
        run_init();
        set_dec(0, 1, 0, 0, 4); eval_cycle(); advance_cycle();
        set_dec(0, 0, 9, 0, 5); eval_cycle(); advance_cycle();
        set_idle(9);
        eval_cycle(); chk("norename_count", dut.fl_count, 32); chk("norename_rd", phys_rd, 32); advance_cycle();
        set_idle(9); ret_v = 1; ret_id = 4; eval_cycle(); advance_cycle();
        set_idle(9); ret_v = 1; ret_id = 5; eval_cycle(); advance_cycle();
        set_idle(9);
        eval_cycle(); chk("noretire_count", dut.fl_count, 32); advance_cycle();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rand_stim();
            eval_cycle();
            advance_cycle();
        end

        // Mid-run reset with renames outstanding.
        apply_reset();
        run_init();
        for (int k = 0; k < 10; k++) begin
            set_dec(0, 1, k + 3, 1, k % 8);
            eval_cycle();
            advance_cycle();
        end
        apply_reset();
        run_init();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
